bp_be_long_scheduler: RTL and testbench

- Sequences the shared iterative long-latency unit (integer div/rem, FP div/sqrt) for the BE calculator. Holds one outstanding long op.
- Drives the unit's start/result handshake and arbitrates the op's late writeback onto the register-file write port. The pipeline's own writeback has priority on that port.
- Exports long_ready_o and a pending-rd hazard flag to the checker's hazard detection.

---
 rtl/bp_be_long_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_bp_be_long_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_long_scheduler.sv
// ---------------------------------------------------------------------------
// bp_be_long_scheduler
//
// Sequences the shared iterative long-latency unit (integer div/rem, FP
// div/sqrt) for the BE calculator. Holds at most one outstanding long op,
// drives the unit's start/result handshake and offers the op's late result
// to the register-file write port. The pipeline's own writeback owns that
// port first, so the result is held until wb_yumi_i grants it.
//
// Optional feature macro: BP_BE_LONG_SCHED_BYPASS_EN
//   defined     -> a new op can be accepted in the same cycle the pending
//                  result is granted (back-to-back ops, no IDLE bubble).
//   not defined -> a new op is accepted only from IDLE.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_v_i                 long op dispatch (legal only when long_ready_o)
//   req_rd_addr_i           destination register of the dispatched op
//   req_iwb_i, req_fwb_i    op writes integer / FP register file
//   long_ready_o            scheduler can accept req_v_i this cycle
//   unit_v_o, unit_ready_i  start handshake towards the iterative unit
//   unit_v_i, unit_data_i   single-cycle result pulse and result data
//   flush_i                 kill of an uncommitted long op
//   isd_rs{1,2,3}_addr_i    issue-stage source addresses
//   isd_irs{1,2}_v_i        issue-stage integer source valids
//   isd_frs{1,2,3}_v_i      issue-stage FP source valids
//   haz_v_o                 an issue source reads the pending long rd
//   iwb_v_o, fwb_v_o        integer / FP writeback request
//   wb_addr_o, wb_data_o    writeback address and data
//   wb_yumi_i               write port granted this cycle
//   err_o                   sticky watchdog error (unit never answered)
// ---------------------------------------------------------------------------
module bp_be_long_scheduler #(
  parameter int reg_addr_width_p = 5,
  parameter int data_width_p     = 64,
  parameter int timeout_p        = 128
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        req_v_i,
  input  logic [reg_addr_width_p-1:0] req_rd_addr_i,
  input  logic                        req_iwb_i,
  input  logic                        req_fwb_i,
  output logic                        long_ready_o,

  output logic                        unit_v_o,
  input  logic                        unit_ready_i,
  input  logic                        unit_v_i,
  input  logic [data_width_p-1:0]     unit_data_i,

  input  logic                        flush_i,

  input  logic [reg_addr_width_p-1:0] isd_rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] isd_rs2_addr_i,
  input  logic [reg_addr_width_p-1:0] isd_rs3_addr_i,
  input  logic                        isd_irs1_v_i,
  input  logic                        isd_irs2_v_i,
  input  logic                        isd_frs1_v_i,
  input  logic                        isd_frs2_v_i,
  input  logic                        isd_frs3_v_i,
  output logic                        haz_v_o,

  output logic                        iwb_v_o,
  output logic                        fwb_v_o,
  output logic [reg_addr_width_p-1:0] wb_addr_o,
  output logic [data_width_p-1:0]     wb_data_o,
  input  logic                        wb_yumi_i,

  output logic                        err_o
);

  localparam int WDOG_W = $clog2(timeout_p + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(timeout_p);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4
  } state_e;

  state_e                      state_r, state_n;
  logic [reg_addr_width_p-1:0] rd_r;
  logic                        iwb_r, fwb_r;
  logic [data_width_p-1:0]     data_r;
  logic [WDOG_W-1:0]           wdog_r, wdog_n;
  logic                        err_r;

  logic                        req_accept;
  logic                        capture;
  logic                        pending;
  logic                        int_haz, fp_haz;
  logic                        rd_nonzero;

  // -------------------------------------------------------------------------
  // Next-state and acceptance logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n      = state_r;
    long_ready_o = (state_r == S_IDLE);
`ifdef BP_BE_LONG_SCHED_BYPASS_EN
    // The granted result leaves this cycle, so the op slot is free again.
    long_ready_o = long_ready_o | ((state_r == S_WB) & wb_yumi_i);
`endif
    req_accept = req_v_i & long_ready_o;

    unique case (state_r)
      S_IDLE: begin
        if (req_accept) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        // Once the unit has taken the start, a flush must still wait for
        // its result pulse so it cannot be mistaken for a later op's.
        if (unit_ready_i)  state_n = flush_i ? S_DRAIN : S_BUSY;
        else if (flush_i)  state_n = S_IDLE;
      end
      S_BUSY: begin
        if (unit_v_i)      state_n = flush_i ? S_IDLE : S_WB;
        else if (flush_i)  state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (unit_v_i) state_n = S_IDLE;
      end
      S_WB: begin
        // The result is committed here, so flush_i has no effect.
        if (wb_yumi_i) state_n = req_accept ? S_ISSUE : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign capture = (state_r == S_BUSY) & unit_v_i & ~flush_i;

  // Watchdog: restarts when the unit accepts the start, counts only while
  // BUSY and saturates so the error condition stays evaluable.
  always_comb begin
    wdog_n = wdog_r;
    if ((state_r == S_ISSUE) & unit_ready_i) begin
      wdog_n = '0;
    end else if ((state_r == S_BUSY) & (wdog_r != WDOG_MAX)) begin
      wdog_n = wdog_r + WDOG_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State, op and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
      rd_r    <= '0;
      iwb_r   <= 1'b0;
      fwb_r   <= 1'b0;
      data_r  <= '0;
      wdog_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      wdog_r  <= wdog_n;
      if (req_accept) begin
        rd_r  <= req_rd_addr_i;
        iwb_r <= req_iwb_i;
        fwb_r <= req_fwb_i;
      end
      if (capture) begin
        data_r <= unit_data_i;
      end
      if ((state_r == S_BUSY) & (wdog_n == WDOG_MAX)) begin
        err_r <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Unit handshake, writeback and hazard outputs
  // -------------------------------------------------------------------------
  assign unit_v_o  = (state_r == S_ISSUE);
  assign iwb_v_o   = (state_r == S_WB) & iwb_r;
  assign fwb_v_o   = (state_r == S_WB) & fwb_r;
  assign wb_addr_o = rd_r;
  assign wb_data_o = data_r;
  assign err_o     = err_r;

  // A flushed op in DRAIN will never write, so it creates no hazard.
  assign pending    = (state_r == S_ISSUE) | (state_r == S_BUSY) | (state_r == S_WB);
  assign rd_nonzero = (rd_r != '0);

  // x0 is hardwired in the integer file, so reading it never depends on
  // the long op; FP f0 is an ordinary register.
  assign int_haz = iwb_r & rd_nonzero
                 & ((isd_irs1_v_i & (isd_rs1_addr_i == rd_r))
                  | (isd_irs2_v_i & (isd_rs2_addr_i == rd_r)));

  assign fp_haz  = fwb_r
                 & ((isd_frs1_v_i & (isd_rs1_addr_i == rd_r))
                  | (isd_frs2_v_i & (isd_rs2_addr_i == rd_r))
                  | (isd_frs3_v_i & (isd_rs3_addr_i == rd_r)));

  assign haz_v_o = pending & (int_haz | fp_haz);

endmodule

// File: tb/tb_bp_be_long_scheduler.sv
module tb_bp_be_long_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_v_i = 1'b0;
  logic [4:0]  req_rd_addr_i = '0;
  logic        req_iwb_i = 1'b0;
  logic        req_fwb_i = 1'b0;
  logic        long_ready_o;
  logic        unit_v_o;
  logic        unit_ready_i = 1'b0;
  logic        unit_v_i = 1'b0;
  logic [63:0] unit_data_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  isd_rs1_addr_i = '0;
  logic [4:0]  isd_rs2_addr_i = '0;
  logic [4:0]  isd_rs3_addr_i = '0;
  logic        isd_irs1_v_i = 1'b0;
  logic        isd_irs2_v_i = 1'b0;
  logic        isd_frs1_v_i = 1'b0;
  logic        isd_frs2_v_i = 1'b0;
  logic        isd_frs3_v_i = 1'b0;
  logic        haz_v_o;
  logic        iwb_v_o;
  logic        fwb_v_o;
  logic [4:0]  wb_addr_o;
  logic [63:0] wb_data_o;
  logic        wb_yumi_i = 1'b0;
  logic        err_o;

  bp_be_long_scheduler #(
    .reg_addr_width_p(5),
    .data_width_p(64),
    .timeout_p(128)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_v_i(req_v_i),
    .req_rd_addr_i(req_rd_addr_i),
    .req_iwb_i(req_iwb_i),
    .req_fwb_i(req_fwb_i),
    .long_ready_o(long_ready_o),
    .unit_v_o(unit_v_o),
    .unit_ready_i(unit_ready_i),
    .unit_v_i(unit_v_i),
    .unit_data_i(unit_data_i),
    .flush_i(flush_i),
    .isd_rs1_addr_i(isd_rs1_addr_i),
    .isd_rs2_addr_i(isd_rs2_addr_i),
    .isd_rs3_addr_i(isd_rs3_addr_i),
    .isd_irs1_v_i(isd_irs1_v_i),
    .isd_irs2_v_i(isd_irs2_v_i),
    .isd_frs1_v_i(isd_frs1_v_i),
    .isd_frs2_v_i(isd_frs2_v_i),
    .isd_frs3_v_i(isd_frs3_v_i),
    .haz_v_o(haz_v_o),
    .iwb_v_o(iwb_v_o),
    .fwb_v_o(fwb_v_o),
    .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o),
    .wb_yumi_i(wb_yumi_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        iwb;
    logic        fwb;
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every granted writeback must match the oldest expected one.
  always @(negedge clk_i) begin
    if ((iwb_v_o | fwb_v_o) & wb_yumi_i) begin
      if (exp_q.size() == 0) begin
        check_val("wb_unexpected", 64'(iwb_v_o | fwb_v_o), 64'd0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check_val("sb_iwb",  64'(iwb_v_o),  64'(e.iwb));
        check_val("sb_fwb",  64'(fwb_v_o),  64'(e.fwb));
        check_val("sb_addr", 64'(wb_addr_o), 64'(e.addr));
        check_val("sb_data", wb_data_o, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic iwb, input logic fwb);
    req_v_i = 1'b1; req_rd_addr_i = rd; req_iwb_i = iwb; req_fwb_i = fwb;
    tick();
    req_v_i = 1'b0; req_iwb_i = 1'b0; req_fwb_i = 1'b0;
  endtask

  task automatic handshake();
    unit_ready_i = 1'b1;
    tick();
    unit_ready_i = 1'b0;
  endtask

  // Unit result pulse that is expected to be written back.
  task automatic result(input logic [4:0] rd, input logic iwb, input logic fwb, input logic [63:0] d);
    wb_exp_t e;
    e.iwb = iwb; e.fwb = fwb; e.addr = rd; e.data = d;
    exp_q.push_back(e);
    unit_v_i = 1'b1; unit_data_i = d;
    tick();
    unit_v_i = 1'b0; unit_data_i = '0;
  endtask

  task automatic grant();
    wb_yumi_i = 1'b1;
    tick();
    wb_yumi_i = 1'b0;
  endtask

  task automatic clear_isd();
    isd_irs1_v_i = 0; isd_irs2_v_i = 0;
    isd_frs1_v_i = 0; isd_frs2_v_i = 0; isd_frs3_v_i = 0;
    isd_rs1_addr_i = '0; isd_rs2_addr_i = '0; isd_rs3_addr_i = '0;
  endtask

  initial begin
    // Reset state
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    check_val("rst_ready", 64'(long_ready_o), 64'd1);
    check_val("rst_unit_v", 64'(unit_v_o), 64'd0);
    check_val("rst_iwb", 64'(iwb_v_o), 64'd0);
    check_val("rst_fwb", 64'(fwb_v_o), 64'd0);
    check_val("rst_haz", 64'(haz_v_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    check_val("rst_addr", 64'(wb_addr_o), 64'd0);
    check_val("rst_data", wb_data_o, 64'd0);

    // Integer div, rd=5, result 20 cycles after start
    dispatch(5'd5, 1'b1, 1'b0);
    check_val("t1_unit_v", 64'(unit_v_o), 64'd1);
    check_val("t1_ready_issue", 64'(long_ready_o), 64'd0);
    handshake();
    check_val("t1_unit_v_drop", 64'(unit_v_o), 64'd0);
    isd_rs1_addr_i = 5'd5; isd_irs1_v_i = 1'b1;
    settle();
    check_val("t1_haz_irs1", 64'(haz_v_o), 64'd1);
    clear_isd();
    for (int i = 0; i < 19; i++) tick();
    check_val("t1_busy_iwb", 64'(iwb_v_o), 64'd0);
    result(5'd5, 1'b1, 1'b0, 64'h2A);
    check_val("t1_iwb", 64'(iwb_v_o), 64'd1);
    check_val("t1_addr", 64'(wb_addr_o), 64'd5);
    check_val("t1_data", wb_data_o, 64'h2A);
    grant();
    check_val("t1_iwb_one_cycle", 64'(iwb_v_o), 64'd0);
    check_val("t1_ready_after", 64'(long_ready_o), 64'd1);

    // FP sqrt, rd=3: source hazards and a held writeback
    dispatch(5'd3, 1'b0, 1'b1);
    isd_rs2_addr_i = 5'd3; isd_frs2_v_i = 1'b1;
    settle();
    check_val("t2_haz_frs2", 64'(haz_v_o), 64'd1);
    isd_frs2_v_i = 1'b0; isd_irs2_v_i = 1'b1;
    settle();
    check_val("t2_haz_irs2", 64'(haz_v_o), 64'd0);
    clear_isd();
    handshake();
    isd_rs3_addr_i = 5'd3; isd_frs3_v_i = 1'b1;
    settle();
    check_val("t2_haz_frs3", 64'(haz_v_o), 64'd1);
    isd_rs3_addr_i = 5'd4;
    settle();
    check_val("t2_haz_frs3_other", 64'(haz_v_o), 64'd0);
    clear_isd();
    for (int i = 0; i < 3; i++) tick();
    result(5'd3, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_hold_fwb", 64'(fwb_v_o), 64'd1);
      check_val("t2_hold_iwb", 64'(iwb_v_o), 64'd0);
      check_val("t2_hold_addr", 64'(wb_addr_o), 64'd3);
      check_val("t2_hold_data", wb_data_o, 64'hDEAD_BEEF_0123_4567);
      check_val("t2_hold_ready", 64'(long_ready_o), 64'd0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    isd_rs1_addr_i = 5'd3; isd_frs1_v_i = 1'b1;
    settle();
    check_val("t2_haz_wb", 64'(haz_v_o), 64'd1);
    clear_isd();
    grant();
    check_val("t2_fwb_done", 64'(fwb_v_o), 64'd0);
    check_val("t2_ready_after", 64'(long_ready_o), 64'd1);

    // Integer op to x0: no hazard, writeback still handshakes
    dispatch(5'd0, 1'b1, 1'b0);
    isd_rs1_addr_i = 5'd0; isd_irs1_v_i = 1'b1;
    settle();
    check_val("t3_haz_x0", 64'(haz_v_o), 64'd0);
    clear_isd();
    handshake();
    tick();
    result(5'd0, 1'b1, 1'b0, 64'h77);
    check_val("t3_iwb_x0", 64'(iwb_v_o), 64'd1);
    grant();

    // Flush in ISSUE without ready: back to IDLE, no handshake
    dispatch(5'd7, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("t4_unit_v", 64'(unit_v_o), 64'd0);
    check_val("t4_ready", 64'(long_ready_o), 64'd1);

    // Flush in BUSY: DRAIN until the result arrives, no writeback
    dispatch(5'd9, 1'b1, 1'b0);
    handshake();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    isd_rs1_addr_i = 5'd9; isd_irs1_v_i = 1'b1;
    settle();
    check_val("t5_haz_drain", 64'(haz_v_o), 64'd0);
    clear_isd();
    for (int i = 0; i < 3; i++) begin
      check_val("t5_ready_drain", 64'(long_ready_o), 64'd0);
      tick();
    end
    unit_v_i = 1'b1; unit_data_i = 64'h55;
    tick();
    unit_v_i = 1'b0; unit_data_i = '0;
    check_val("t5_ready_idle", 64'(long_ready_o), 64'd1);
    check_val("t5_no_wb", 64'(iwb_v_o | fwb_v_o), 64'd0);
    wb_yumi_i = 1'b1;
    tick(); tick();
    wb_yumi_i = 1'b0;

    // Flush together with ready in ISSUE: DRAIN
    dispatch(5'd10, 1'b1, 1'b0);
    unit_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    unit_ready_i = 1'b0; flush_i = 1'b0;
    check_val("t6_drain_ready", 64'(long_ready_o), 64'd0);
    check_val("t6_drain_unit_v", 64'(unit_v_o), 64'd0);
    unit_v_i = 1'b1;
    tick();
    unit_v_i = 1'b0;
    check_val("t6_idle", 64'(long_ready_o), 64'd1);

    // Flush together with the result in BUSY: straight to IDLE
    dispatch(5'd11, 1'b1, 1'b0);
    handshake();
    unit_v_i = 1'b1; flush_i = 1'b1; unit_data_i = 64'h99;
    tick();
    unit_v_i = 1'b0; flush_i = 1'b0; unit_data_i = '0;
    check_val("t7_idle", 64'(long_ready_o), 64'd1);
    check_val("t7_no_wb", 64'(iwb_v_o), 64'd0);

    // New request in the yumi cycle
    dispatch(5'd4, 1'b1, 1'b0);
    handshake();
    result(5'd4, 1'b1, 1'b0, 64'h11);
    wb_yumi_i = 1'b1;
    req_v_i = 1'b1; req_rd_addr_i = 5'd6; req_iwb_i = 1'b1;
    settle();
`ifdef BP_BE_LONG_SCHED_BYPASS_EN
    check_val("t8_ready_yumi", 64'(long_ready_o), 64'd1);
`else
    check_val("t8_ready_yumi", 64'(long_ready_o), 64'd0);
`endif
    tick();
    wb_yumi_i = 1'b0; req_v_i = 1'b0; req_iwb_i = 1'b0;
`ifdef BP_BE_LONG_SCHED_BYPASS_EN
    check_val("t8_unit_v_b2b", 64'(unit_v_o), 64'd1);
    handshake();
    result(5'd6, 1'b1, 1'b0, 64'h66);
    grant();
`else
    check_val("t8_unit_v_refused", 64'(unit_v_o), 64'd0);
    check_val("t8_ready_idle", 64'(long_ready_o), 64'd1);
`endif

    // Watchdog: err_o exactly 128 cycles after entering BUSY, sticky
    dispatch(5'd2, 1'b1, 1'b0);
    handshake();
    for (int i = 0; i < 127; i++) tick();
    check_val("t9_err_127", 64'(err_o), 64'd0);
    tick();
    check_val("t9_err_128", 64'(err_o), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    result(5'd2, 1'b1, 1'b0, 64'h1234);
    grant();
    check_val("t9_err_sticky", 64'(err_o), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    check_val("t9_err_idle", 64'(err_o), 64'd1);

    // Reset mid-op: IDLE next cycle, late result ignored, err cleared
    dispatch(5'd12, 1'b1, 1'b0);
    handshake();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_val("t10_ready", 64'(long_ready_o), 64'd1);
    check_val("t10_err_clr", 64'(err_o), 64'd0);
    check_val("t10_addr_clr", 64'(wb_addr_o), 64'd0);
    unit_v_i = 1'b1; unit_data_i = 64'hBAD;
    tick();
    unit_v_i = 1'b0; unit_data_i = '0;
    wb_yumi_i = 1'b1;
    tick();
    wb_yumi_i = 1'b0;
    check_val("t10_no_wb", 64'(iwb_v_o | fwb_v_o), 64'd0);
    check_val("t10_data_clr", wb_data_o, 64'd0);

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
